// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver with 3-sample majority voting and a one-word holding register
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 12,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk_s,
    input  logic                 rst_s,
    input  logic                 iDATA,
    input  logic                 iREADY,
    output logic [DATA_BITS-1:0] oDATA,
    output logic                 oVALID,
    output logic                 oDONE,
    output logic                 oPERR,
    output logic                 oFERR,
    output logic                 oOVR,
    output logic                 oBUSY
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int MID = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] SMP_A    = CW'(MID - 1);
    localparam logic [CW-1:0] SMP_B    = CW'(MID);
    localparam logic [CW-1:0] SMP_C    = CW'(MID + 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic          ODD_PAR  = (PARITY == 2);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PAR       = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_HIGH = 3'd5;

    logic [1:0]           sync_q;
    logic                 rx_prev;
    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic [1:0]           samp;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr_acc;
    logic                 ferr_acc;

    logic rx;
    logic majority;
    logic at_decide;
    logic at_end;
    logic complete;
    logic frame_ferr;
    logic handshake;
    logic hold_free;
    logic par_exp;

    always_comb begin
        rx         = sync_q[1];
        majority   = (samp[0] & samp[1]) | (samp[0] & rx) | (samp[1] & rx);
        at_decide  = (cnt == SMP_C);
        at_end     = (cnt == CNT_LAST);
        complete   = (state == S_STOP) && at_decide && (bit_idx == LAST_STOP);
        frame_ferr = ferr_acc | ~majority;
        handshake  = oVALID & iREADY;
        hold_free  = ~oVALID | iREADY;
        par_exp    = (^shreg) ^ ODD_PAR;
        oBUSY      = (state != S_IDLE);
    end

    // Output holding register: a completed frame either loads or is dropped as an overrun.
    always_ff @(posedge clk_s) begin
        if (rst_s) begin
            oDATA  <= '0;
            oVALID <= 1'b0;
            oDONE  <= 1'b0;
            oPERR  <= 1'b0;
            oFERR  <= 1'b0;
            oOVR   <= 1'b0;
        end else begin
            oDONE <= complete;
            if (complete && hold_free) begin
                oDATA  <= shreg;
                oPERR  <= perr_acc;
                oFERR  <= frame_ferr;
                oVALID <= 1'b1;
            end else if (handshake) begin
                oVALID <= 1'b0;
            end
            if (complete && !hold_free) begin
                oOVR <= 1'b1;
            end else if (handshake) begin
                oOVR <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_s) begin
        if (rst_s) begin
            sync_q   <= 2'b11;
            rx_prev  <= 1'b1;
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            samp     <= 2'b11;
            shreg    <= '0;
            perr_acc <= 1'b0;
            ferr_acc <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], iDATA};
            rx_prev <= rx;

            if (state == S_IDLE || state == S_WAIT_HIGH) begin
                cnt <= '0;
            end else begin
                cnt <= at_end ? '0 : cnt + CNT_ONE;
            end
            if (cnt == SMP_A) begin
                samp[0] <= rx;
            end
            if (cnt == SMP_B) begin
                samp[1] <= rx;
            end

            case (state)
                S_IDLE: begin
                    if (rx_prev && !rx) begin
                        state    <= S_START;
                        bit_idx  <= '0;
                        perr_acc <= 1'b0;
                        ferr_acc <= 1'b0;
                    end
                end
                S_START: begin
                    if (at_decide && majority) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else if (at_end) begin
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (at_decide) begin
                        shreg <= {majority, shreg[DATA_BITS-1:1]};
                    end
                    if (at_end) begin
                        if (bit_idx == LAST_DATA) begin
                            bit_idx <= '0;
                            state   <= (PARITY != 0) ? S_PAR : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end
                end
                S_PAR: begin
                    if (at_decide) begin
                        perr_acc <= (majority != par_exp);
                    end
                    if (at_end) begin
                        state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (at_decide && !majority) begin
                        ferr_acc <= 1'b1;
                    end
                    // The frame ends at the last stop bit's decision point so the next start edge is never missed.
                    if (complete) begin
                        state <= majority ? S_IDLE : S_WAIT_HIGH;
                        cnt   <= '0;
                    end else if (at_end) begin
                        bit_idx <= bit_idx + 4'd1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - scoreboard bench for uart_rx_cfg (default instance and even-parity two-stop instance)
module tb_uart_rx_cfg;

    localparam int CPB = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       line_a, line_b, ready_a, ready_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, done_a, perr_a, ferr_a, ovr_a, busy_a;
    logic       valid_b, done_b, perr_b, ferr_b, ovr_b, busy_b;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB)) dut_a (
        .clk_s(clk), .rst_s(rst), .iDATA(line_a), .iREADY(ready_a),
        .oDATA(data_a), .oVALID(valid_a), .oDONE(done_a), .oPERR(perr_a),
        .oFERR(ferr_a), .oOVR(ovr_a), .oBUSY(busy_a)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) dut_b (
        .clk_s(clk), .rst_s(rst), .iDATA(line_b), .iREADY(ready_b),
        .oDATA(data_b), .oVALID(valid_b), .oDONE(done_b), .oPERR(perr_b),
        .oFERR(ferr_b), .oOVR(ovr_b), .oBUSY(busy_b)
    );

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovr;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    int   n_checks = 0;
    int   n_err = 0;
    int   cnt_done_a = 0;
    int   cnt_done_b = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done_a === 1'b1) begin
            cnt_done_a++;
            check_val("a_queue_nonempty", (q_a.size() != 0), 1);
            if (q_a.size() != 0) begin
                ea = q_a.pop_front();
                check_val("a_data", data_a, ea.data);
                check_val("a_perr", perr_a, ea.perr);
                check_val("a_ferr", ferr_a, ea.ferr);
                check_val("a_valid", valid_a, 1);
                check_val("a_ovr", ovr_a, ea.ovr);
            end
        end
        if (done_b === 1'b1) begin
            cnt_done_b++;
            check_val("b_queue_nonempty", (q_b.size() != 0), 1);
            if (q_b.size() != 0) begin
                eb = q_b.pop_front();
                check_val("b_data", data_b, eb.data);
                check_val("b_perr", perr_b, eb.perr);
                check_val("b_ferr", ferr_b, eb.ferr);
                check_val("b_valid", valid_b, 1);
                check_val("b_ovr", ovr_b, eb.ovr);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input bit b, input bit v);
        @(negedge clk);
        if (b) line_b = v;
        else   line_a = v;
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic idle(input bit b, input int n);
        @(negedge clk);
        if (b) line_b = 1'b1;
        else   line_a = 1'b1;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic send(input bit b, input logic [7:0] d, input bit par_en, input bit par_bit,
                        input int nstop, input bit stop_bit);
        drive(b, 1'b0);
        for (int i = 0; i < 8; i++) drive(b, d[i]);
        if (par_en) drive(b, par_bit);
        for (int i = 0; i < nstop; i++) drive(b, stop_bit);
    endtask

    task automatic pulse_ready(input bit b);
        @(negedge clk);
        if (b) ready_b = 1'b1;
        else   ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
        ready_b = 1'b0;
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic p, input logic f, input logic o);
        exp_t e;
        e.data = d; e.perr = p; e.ferr = f; e.ovr = o;
        return e;
    endfunction

    int busy_cycles;
    logic [7:0] abort_word;

    initial begin
        rst = 1'b1; line_a = 1'b1; line_b = 1'b1; ready_a = 1'b0; ready_b = 1'b0;
        cycles(3);
        check_val("rst_data", data_a, 0);
        check_val("rst_valid", valid_a, 0);
        check_val("rst_done", done_a, 0);
        check_val("rst_perr", perr_a, 0);
        check_val("rst_ferr", ferr_a, 0);
        check_val("rst_ovr", ovr_a, 0);
        check_val("rst_busy", busy_a, 0);
        rst = 1'b0;
        cycles(5);

        // Default frame, held until the consumer accepts it
        q_a.push_back(mk(8'h55, 0, 0, 0));
        send(0, 8'h55, 0, 0, 1, 1'b1);
        idle(0, 20);
        check_val("hold_done_cnt", cnt_done_a, 1);
        check_val("hold_valid", valid_a, 1);
        check_val("hold_data", data_a, 8'h55);
        pulse_ready(0);
        check_val("ack_valid", valid_a, 0);
        check_val("ack_data_kept", data_a, 8'h55);

        // Short glitch on the idle line is rejected as a false start
        @(negedge clk); line_a = 1'b0;
        cycles(3);
        line_a = 1'b1;
        busy_cycles = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy_a) busy_cycles++;
        end
        check_val("glitch_busy_seen", (busy_cycles > 0), 1);
        check_val("glitch_busy_le_bit", (busy_cycles <= CPB), 1);
        check_val("glitch_no_done", cnt_done_a, 1);
        check_val("glitch_idle", busy_a, 0);

        // Framing error with the line stuck low afterwards
        q_a.push_back(mk(8'h0F, 0, 1, 0));
        send(0, 8'h0F, 0, 0, 1, 1'b0);
        cycles(40);
        check_val("ferr_done_cnt", cnt_done_a, 2);
        check_val("wait_high_busy", busy_a, 1);
        idle(0, 6);
        check_val("wait_high_released", busy_a, 0);
        check_val("ferr_no_extra_done", cnt_done_a, 2);
        pulse_ready(0);
        check_val("ferr_ack_valid", valid_a, 0);

        // Overrun: second frame dropped while the first is still held
        q_a.push_back(mk(8'h11, 0, 0, 0));
        send(0, 8'h11, 0, 0, 1, 1'b1);
        idle(0, 5);
        q_a.push_back(mk(8'h11, 0, 0, 1));
        send(0, 8'h22, 0, 0, 1, 1'b1);
        idle(0, 5);
        check_val("ovr_done_cnt", cnt_done_a, 4);
        check_val("ovr_data_kept", data_a, 8'h11);
        pulse_ready(0);
        check_val("ovr_ack_valid", valid_a, 0);
        check_val("ovr_ack_cleared", ovr_a, 0);

        // Parity instance: even parity, two stop bits
        q_b.push_back(mk(8'hA3, 1, 0, 0));
        send(1, 8'hA3, 1, 1'b1, 2, 1'b1);
        idle(1, 5);
        check_val("par_bad_done_cnt", cnt_done_b, 1);
        pulse_ready(1);
        q_b.push_back(mk(8'hA3, 0, 0, 0));
        send(1, 8'hA3, 1, 1'b0, 2, 1'b1);
        idle(1, 5);
        check_val("par_good_done_cnt", cnt_done_b, 2);
        check_val("par_good_perr", perr_b, 0);

        // Reset in the middle of data bit 4 aborts the frame
        abort_word = 8'hC3;
        drive(0, 1'b0);
        for (int i = 0; i < 4; i++) drive(0, abort_word[i]);
        @(negedge clk); line_a = abort_word[4];
        cycles(CPB / 2);
        rst = 1'b1; line_a = 1'b1; line_b = 1'b1;
        @(negedge clk);
        check_val("mid_rst_data", data_a, 0);
        check_val("mid_rst_valid", valid_a, 0);
        check_val("mid_rst_done", done_a, 0);
        check_val("mid_rst_perr", perr_a, 0);
        check_val("mid_rst_ferr", ferr_a, 0);
        check_val("mid_rst_ovr", ovr_a, 0);
        check_val("mid_rst_busy", busy_a, 0);
        rst = 1'b0;
        idle(0, 2 * CPB);
        check_val("mid_rst_no_done", cnt_done_a, 4);
        q_a.push_back(mk(8'hC3, 0, 0, 0));
        send(0, 8'hC3, 0, 0, 1, 1'b1);
        idle(0, 10);
        check_val("after_rst_done_cnt", cnt_done_a, 5);
        check_val("after_rst_data", data_a, 8'hC3);

        check_val("a_queue_drained", q_a.size(), 0);
        check_val("b_queue_drained", q_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
